// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the req/ack instruction memory, loads IF/ID,
// and tells the PC register when to advance, redirect or hold.
module fetch_stage #(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  output logic [15:0] NewPC,
  output logic        StopPC,
  output logic        Halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc2,
  output logic        ifid_valid
);

  localparam logic [1:0] FETCH    = 2'd0;
  localparam logic [1:0] BUFFERED = 2'd1;
  localparam logic [1:0] DISCARD  = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  logic [1:0]  state;
  logic [15:0] skidInstr;
  logic [15:0] skidPc2;
  logic [15:0] pcPlus2;
  logic        advance;
  logic        outstanding;

  assign pcPlus2   = PC + 16'd2;
  assign imem_addr = PC;
  assign imem_req  = !rst && ((state == FETCH) || (state == DISCARD));
  assign Halt      = (state == HALTED);

  // A request issued this cycle and not answered stays in flight past the edge.
  assign outstanding = imem_req && !imem_ack;

  assign advance = !redirect &&
                   (((state == FETCH) && imem_ack && !stall) ||
                    ((state == BUFFERED) && !stall));

  assign NewPC  = redirect ? {redirect_pc[15:1], 1'b0} : pcPlus2;
  assign StopPC = !(advance || redirect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      skidInstr  <= 16'd0;
      skidPc2    <= 16'd0;
      ifid_instr <= 16'd0;
      ifid_pc2   <= 16'd0;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      state      <= outstanding ? DISCARD : FETCH;
      ifid_valid <= 1'b0;
      skidInstr  <= 16'd0;
      skidPc2    <= 16'd0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (!stall) begin
              ifid_instr <= imem_rdata;
              ifid_pc2   <= pcPlus2;
              ifid_valid <= 1'b1;
              state      <= (imem_rdata[15:12] == HALT_OP) ? HALTED : FETCH;
            end else begin
              skidInstr <= imem_rdata;
              skidPc2   <= pcPlus2;
              state     <= BUFFERED;
            end
          end
        end
        BUFFERED: begin
          if (!stall) begin
            ifid_instr <= skidInstr;
            ifid_pc2   <= skidPc2;
            ifid_valid <= 1'b1;
            skidInstr  <= 16'd0;
            skidPc2    <= 16'd0;
            state      <= (skidInstr[15:12] == HALT_OP) ? HALTED : FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) state <= FETCH;
        end
        HALTED: begin
          if (!stall) ifid_valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays PC register and memory,
// expected IF/ID loads go through a scoreboard queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC;
  logic [15:0] NewPC;
  logic        StopPC;
  logic        Halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;

  int nChecks = 0;
  int nFail   = 0;
  logic [31:0] sbQ[$];

  fetch_stage #(.HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .PC(PC), .NewPC(NewPC), .StopPC(StopPC), .Halt(Halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ifid_instr(ifid_instr), .ifid_pc2(ifid_pc2),
    .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushLoad(input logic [15:0] instr, input logic [15:0] pc2);
    sbQ.push_back({instr, pc2});
  endtask

  task automatic checkLoad(input string tag);
    logic [31:0] e;
    if (sbQ.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      chk({tag, "_instr"}, {16'd0, ifid_instr}, {16'd0, e[31:16]});
      chk({tag, "_pc2"},   {16'd0, ifid_pc2},   {16'd0, e[15:0]});
      chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    end
  endtask

  // Acts as the PC register: load NewPC unless StopPC, then settle past the edge.
  task automatic tick();
    logic [15:0] nxt;
    nxt = StopPC ? PC : NewPC;
    @(posedge clk);
    #1;
    PC = nxt;
    #1;
  endtask

  task automatic drive(input logic ack, input logic [15:0] rdata, input logic stl,
                       input logic rdr, input logic [15:0] rpc);
    imem_ack = ack; imem_rdata = rdata; stall = stl; redirect = rdr; redirect_pc = rpc;
    #1;
  endtask

  initial begin
    rst = 1'b1; PC = 16'd0;
    imem_ack = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;
    #2;
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", {16'd0, ifid_instr}, 32'd0);
    chk("rst_pc2",   {16'd0, ifid_pc2},   32'd0);
    chk("rst_halt",  {31'd0, Halt},       32'd0);
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Zero-wait stream
    drive(1, 16'h1111, 0, 0, 0);
    chk("zw_req",   {31'd0, imem_req}, 32'd1);
    chk("zw_addr",  {16'd0, imem_addr}, 32'd0);
    chk("zw_stop0", {31'd0, StopPC}, 32'd0);
    chk("zw_newpc", {16'd0, NewPC}, 32'd2);
    pushLoad(16'h1111, 16'h0002);
    tick();
    checkLoad("zw0");
    drive(1, 16'h2222, 0, 0, 0);
    chk("zw_stop1", {31'd0, StopPC}, 32'd0);
    pushLoad(16'h2222, 16'h0004);
    tick();
    checkLoad("zw1");
    chk("zw_pc", {16'd0, PC}, 32'h0004);

    // Two wait cycles at 0x0010
    PC = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      drive(0, 16'h0000, 0, 0, 0);
      chk("w_stop", {31'd0, StopPC}, 32'd1);
      tick();
      chk("w_pchold", {16'd0, PC}, 32'h0010);
      chk("w_ifid",   {16'd0, ifid_pc2}, 32'h0004);
    end
    drive(1, 16'hABCD, 0, 0, 0);
    chk("w_stopack", {31'd0, StopPC}, 32'd0);
    pushLoad(16'hABCD, 16'h0012);
    tick();
    checkLoad("wait");

    // Ack with stall: buffered for three stall cycles
    drive(1, 16'h5555, 1, 0, 0);
    chk("st_stop", {31'd0, StopPC}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 16'h0000, 1, 0, 0);
      chk("st_req",  {31'd0, imem_req}, 32'd0);
      chk("st_stopb", {31'd0, StopPC}, 32'd1);
      tick();
      chk("st_ifid", {16'd0, ifid_instr}, 32'hABCD);
      chk("st_pc",   {16'd0, PC}, 32'h0012);
    end
    drive(0, 16'h0000, 0, 0, 0);
    chk("st_rel_stop", {31'd0, StopPC}, 32'd0);
    chk("st_rel_new",  {16'd0, NewPC}, 32'h0014);
    pushLoad(16'h5555, 16'h0014);
    tick();
    checkLoad("skid");
    chk("st_pcadv",  {16'd0, PC}, 32'h0014);
    chk("st_reqnext", {31'd0, imem_req}, 32'd1);

    // Redirect while waiting: stale ack must be discarded
    drive(0, 16'h0000, 0, 1, 16'h0041);
    chk("rd_new",  {16'd0, NewPC}, 32'h0040);
    chk("rd_stop", {31'd0, StopPC}, 32'd0);
    tick();
    chk("rd_pc",    {16'd0, PC}, 32'h0040);
    chk("rd_valid", {31'd0, ifid_valid}, 32'd0);
    drive(0, 16'h0000, 0, 0, 0);
    chk("dc_req",  {31'd0, imem_req}, 32'd1);
    chk("dc_addr", {16'd0, imem_addr}, 32'h0040);
    chk("dc_stop", {31'd0, StopPC}, 32'd1);
    tick();
    drive(1, 16'hDEAD, 0, 0, 0);
    chk("dc_stopack", {31'd0, StopPC}, 32'd1);
    tick();
    chk("dc_valid", {31'd0, ifid_valid}, 32'd0);
    chk("dc_pc",    {16'd0, PC}, 32'h0040);
    drive(1, 16'h7777, 0, 0, 0);
    pushLoad(16'h7777, 16'h0042);
    tick();
    checkLoad("after_discard");

    // HALT detection and exit via redirect
    drive(1, 16'hF000, 0, 0, 0);
    pushLoad(16'hF000, 16'h0044);
    tick();
    checkLoad("halt");
    chk("h_halt", {31'd0, Halt}, 32'd1);
    drive(0, 16'h0000, 0, 0, 0);
    chk("h_req",  {31'd0, imem_req}, 32'd0);
    chk("h_stop", {31'd0, StopPC}, 32'd1);
    tick();
    chk("h_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("h_halt2",  {31'd0, Halt}, 32'd1);
    drive(0, 16'h0000, 0, 1, 16'h0100);
    chk("h_rd_stop", {31'd0, StopPC}, 32'd0);
    chk("h_rd_new",  {16'd0, NewPC}, 32'h0100);
    tick();
    chk("h_cleared", {31'd0, Halt}, 32'd0);
    chk("h_rd_pc",   {16'd0, PC}, 32'h0100);
    drive(1, 16'h1234, 0, 0, 0);
    chk("h_resume_req", {31'd0, imem_req}, 32'd1);
    pushLoad(16'h1234, 16'h0102);
    tick();
    checkLoad("resume");

    // PC wrap and asynchronous reset mid-stream
    PC = 16'hFFFE;
    drive(1, 16'h4321, 0, 0, 0);
    chk("wr_new", {16'd0, NewPC}, 32'h0000);
    pushLoad(16'h4321, 16'h0000);
    tick();
    checkLoad("wrap");
    drive(1, 16'h9999, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("arst_instr", {16'd0, ifid_instr}, 32'd0);
    chk("arst_pc2",   {16'd0, ifid_pc2},   32'd0);
    chk("arst_halt",  {31'd0, Halt},       32'd0);
    chk("arst_req",   {31'd0, imem_req},   32'd0);
    chk("sb_drained", sbQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It sits directly downstream of the PC register: it takes the current PC, fetches the instruction through a req/ack instruction-memory port, and loads the IF/ID pipeline register. It drives NewPC, StopPC and Halt back into the PC register, and it applies hazard-unit stalls, branch redirects and HALT detection.

## Interface
Parameters:
- HALT_OP, 4'hF, opcode value in instr[15:12] that denotes HALT.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC  in  16  current PC from the PC register.
- NewPC  out  16  next PC to the PC register (combinational).
- StopPC  out  1  PC register must hold when 1 (combinational).
- Halt  out  1  registered; 1 while in HALTED.
- imem_req  out  1  fetch request; address is valid while high.
- imem_addr  out  16  fetch address; always equals PC.
- imem_ack  in  1  memory returns imem_rdata this cycle; may be high in the same cycle as the request.
- imem_rdata  in  16  fetched instruction.
- stall  in  1  hazard unit: hold IF/ID and PC.
- redirect  in  1  taken branch/jump from EX: flush the front end.
- redirect_pc  in  16  target PC; bit 0 is forced to 0.
- ifid_instr  out  16  IF/ID instruction.
- ifid_pc2  out  16  IF/ID PC+2.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Reset is asynchronous and active-high: clk and rst; reset is asynchronous and active-high. While rst is high:
  - state=FETCH;
  - ifid_instr=0, ifid_pc2=0, ifid_valid=0;
  - skid buffer empty; Halt=0; imem_req=0.
- Priority, highest first: rst > redirect > stall > normal fetch.
- "Advance" means the PC register loads NewPC this edge (StopPC=0).
- States:
  - FETCH:
    - imem_req=1.
    - ack & !stall: IF/ID <= {rdata, PC+2, valid=1}; advance with NewPC=PC+2.
    - ack & stall: store {rdata, PC+2} in the one-entry skid buffer; go to BUFFERED; StopPC=1.
    - No ack: StopPC=1 and IF/ID is unchanged.
  - BUFFERED:
    - imem_req=0; StopPC=1 while stall is high.
    - When stall drops: IF/ID <= skid contents, skid empties, advance with NewPC=PC+2, go to FETCH.
  - DISCARD:
    - Entered when a redirect occurs in FETCH with no ack in that cycle, so a request is still outstanding.
    - imem_req=1, with the address now the new PC.
    - The next ack is dropped and the state goes to FETCH; StopPC=1 until then.
  - HALTED:
    - Entered when an instruction with instr[15:12]==HALT_OP is loaded into IF/ID (directly or from the skid buffer).
    - The HALT itself is valid in IF/ID; each later edge loads a bubble, unless stall is high, in which case IF/ID holds.
    - imem_req=0, StopPC=1, Halt=1.
    - Exited only by rst or redirect.
- Redirect, in any state:
  - NewPC={redirect_pc[15:1],1'b0} and StopPC=0.
  - Next edge: ifid_valid=0 and the skid buffer is emptied.
  - Next state is DISCARD if a request was outstanding without ack, otherwise FETCH.
  - Redirect overrides stall.
- StopPC=0 exactly when advancing or redirecting.
- Width rule: PC+2 is computed mod 2^16, so 16'hFFFE wraps to 16'h0000.
- Stall with no new fetch: IF/ID holds its value, including ifid_valid.

## Timing
- Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle: PC=n at edge k gives IF/ID pc2=n+2 at edge k+1.
- With N wait cycles, the PC holds for N cycles and IF/ID loads on the edge where ack is seen.
- Stall release from BUFFERED: IF/ID updates on the first edge with stall=0; the new fetch request starts in the following cycle.
- Redirect at edge k: at edge k, PC=target and IF/ID becomes a bubble; the first target instruction can reach IF/ID at edge k+1 (zero-wait).
- Halt rises on the edge that loads the HALT instruction into IF/ID.
- rst asserted mid-fetch: outputs go to reset values immediately; an in-flight ack after rst is released is ignored only if it arrives while in DISCARD. Memory must drop outstanding requests on rst.

## Test plan
- Zero-wait stream: PC=0, rdata=0x1111, 0x2222 -> IF/ID pc2 = 2 then 4, ifid_valid=1 every cycle, StopPC=0.
- 2-wait memory at PC=0x0010 -> StopPC=1 for 2 cycles; IF/ID={0xABCD, 0x0012} on the ack edge.
- ack together with stall for 3 cycles -> BUFFERED, imem_req=0, IF/ID unchanged; on release IF/ID=skid contents and PC advances by 2.
- Redirect to 0x0041 while waiting for ack -> NewPC=0x0040, ifid_valid=0, the stale ack is discarded, the next ack loads pc2=0x0042.
- Fetch 0xF000 -> Halt=1 on that edge, imem_req=0, bubbles follow; a redirect then clears Halt and fetching resumes.
- PC=0xFFFE zero-wait fetch -> NewPC=0x0000; assert rst mid-stream -> all outputs are 0 asynchronously.
